// File: rtl/timekeeper_pkg.sv
// timekeeper_pkg: shared state encoding, edit codes, BCD limits and BCD increment
package timekeeper_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, SET_H = 2'd1, SET_M = 2'd2} state_t;
  localparam logic [1:0] EDIT_RUN = 2'b00;
  localparam logic [1:0] EDIT_H = 2'b10;
  localparam logic [1:0] EDIT_M = 2'b01;
  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MINSEC_MAX = 8'h59;
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    return v == lim ? 8'h00 : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stable-count debouncer and press-edge pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic level, level_q;
  // count cycles of disagreement; the level flips one edge after the count completes
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      cnt <= '0;
      level <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      level_q <= level;
      if (cnt == CW'(DEBOUNCE_CYCLES)) begin
        level <= ~level;
        cnt <= '0;
      end else begin
        cnt <= sync[1] != level ? cnt + 1'b1 : '0;
      end
    end
  end
  assign press = level & ~level_q;
endmodule

// File: rtl/bcd_timekeeper.sv
// bcd_timekeeper: 1 Hz prescaler, BCD hh:mm:ss counters and button-driven set mode
module bcd_timekeeper
  import timekeeper_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] bcd_h,
  output logic [7:0] bcd_m,
  output logic [7:0] bcd_s,
  output logic [1:0] edit,
  output logic       tick_1hz
);
  localparam int PW = $clog2(CLK_HZ);
  state_t state, state_n;
  logic [PW-1:0] pre;
  logic mode_ev, inc_ev, wrap, s_wrap, m_wrap, inc_h, inc_m, leave;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk(clk), .reset(reset), .raw(btn_mode), .press(mode_ev)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clk(clk), .reset(reset), .raw(btn_inc), .press(inc_ev)
  );
  assign wrap = state == RUN && pre == PW'(CLK_HZ - 1);
  assign s_wrap = bcd_s == MINSEC_MAX;
  assign m_wrap = bcd_m == MINSEC_MAX;
  assign inc_h = state == SET_H && inc_ev && !mode_ev;
  assign inc_m = state == SET_M && inc_ev && !mode_ev;
  assign leave = state == SET_M && mode_ev;
  assign edit = state == SET_H ? EDIT_H : state == SET_M ? EDIT_M : EDIT_RUN;
  // mode events cycle RUN -> SET_H -> SET_M -> RUN
  always_comb begin
    state_n = state;
    if (mode_ev) state_n = state == RUN ? SET_H : state == SET_H ? SET_M : RUN;
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else state <= state_n;
  end
  // prescaler runs only in RUN; fields advance on ticks with carry, or on inc events without carry
  always_ff @(posedge clk) begin
    if (reset) begin
      pre <= '0;
      tick_1hz <= 1'b0;
      bcd_h <= 8'h00;
      bcd_m <= 8'h00;
      bcd_s <= 8'h00;
    end else begin
      pre <= (state != RUN || wrap) ? '0 : pre + 1'b1;
      tick_1hz <= wrap;
      if (wrap) bcd_s <= bcd_inc(bcd_s, MINSEC_MAX);
      else if (leave) bcd_s <= 8'h00;
      if ((wrap && s_wrap) || inc_m) bcd_m <= bcd_inc(bcd_m, MINSEC_MAX);
      if ((wrap && s_wrap && m_wrap) || inc_h) bcd_h <= bcd_inc(bcd_h, HOUR_MAX);
    end
  end
endmodule

// File: tb/tb_bcd_timekeeper.sv
// tb_bcd_timekeeper: directed table-driven and sequence checks of bcd_timekeeper
module tb_bcd_timekeeper;
  logic clk, reset, btn_mode, btn_inc, tick_1hz;
  logic [7:0] bcd_h, bcd_m, bcd_s;
  logic [1:0] edit;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       is_mode;
    int         n;
    logic [1:0] edit;
    logic [7:0] h;
    logic [7:0] m;
  } vec_t;
  vec_t tbl [7];

  bcd_timekeeper #(.CLK_HZ(10), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .bcd_h(bcd_h), .bcd_m(bcd_m), .bcd_s(bcd_s), .edit(edit), .tick_1hz(tick_1hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step;
      n++;
    end while (!tick_1hz && n < 40);
    if (!tick_1hz) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: got no tick after %0d cycles expected one", n);
    end
  endtask

  task automatic pulse(input logic m);
    if (m) btn_mode = 1'b1;
    else btn_inc = 1'b1;
    repeat (10) step;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    repeat (10) step;
  endtask

  task automatic apply(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      repeat (tbl[i].n) pulse(tbl[i].is_mode);
      chk($sformatf("tbl%0d_edit", i), 32'(edit), 32'(tbl[i].edit));
      chk($sformatf("tbl%0d_h", i), 32'(bcd_h), 32'(tbl[i].h));
      chk($sformatf("tbl%0d_m", i), 32'(bcd_m), 32'(tbl[i].m));
    end
  endtask

  initial begin
    int n, first;
    logic [7:0] s_first;
    tbl[0] = '{1'b1, 1, 2'b10, 8'h00, 8'h00};
    tbl[1] = '{1'b0, 25, 2'b10, 8'h01, 8'h00};
    tbl[2] = '{1'b1, 1, 2'b01, 8'h01, 8'h00};
    tbl[3] = '{1'b0, 61, 2'b01, 8'h01, 8'h01};
    tbl[4] = '{1'b1, 1, 2'b10, 8'h01, 8'h01};
    tbl[5] = '{1'b0, 21, 2'b10, 8'h23, 8'h01};
    tbl[6] = '{1'b0, 58, 2'b01, 8'h23, 8'h59};
    reset = 1'b1;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    repeat (3) step;
    reset = 1'b0;
    chk("rst_h", 32'(bcd_h), 32'h00);
    chk("rst_m", 32'(bcd_m), 32'h00);
    chk("rst_s", 32'(bcd_s), 32'h00);
    chk("rst_edit", 32'(edit), 32'h0);
    chk("rst_tick", 32'(tick_1hz), 32'h0);
    for (int k = 1; k <= 10; k++) begin
      wait_tick(n);
      chk($sformatf("run_interval%0d", k), 32'(n), 32'd10);
      chk($sformatf("run_s%0d", k), 32'(bcd_s), 32'((k / 10) * 16 + k % 10));
    end
    apply(0, 3);
    btn_mode = 1'b1;
    first = 0;
    s_first = 8'hff;
    for (int c = 1; c <= 30; c++) begin
      step;
      if (c == 10) btn_mode = 1'b0;
      if (c == 7) chk("exit_edit_before", 32'(edit), 32'h1);
      if (c == 8) begin
        chk("exit_edit_after", 32'(edit), 32'h0);
        chk("exit_s_clear", 32'(bcd_s), 32'h00);
      end
      if (tick_1hz && first == 0) begin
        first = c;
        s_first = bcd_s;
      end
    end
    chk("exit_first_tick", 32'(first), 32'd18);
    chk("exit_first_s", 32'(s_first), 32'h01);
    apply(4, 4);
    for (int c = 0; c < 30; c++) begin
      btn_inc = ((c / 3) % 2) == 0;
      step;
    end
    btn_inc = 1'b0;
    repeat (10) step;
    chk("bounce_h", 32'(bcd_h), 32'h01);
    btn_inc = 1'b1;
    repeat (3) step;
    btn_inc = 1'b0;
    repeat (10) step;
    chk("short_pulse_h", 32'(bcd_h), 32'h01);
    btn_inc = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      step;
      if (c == 4) btn_inc = 1'b0;
      if (c == 7) chk("pulse4_before", 32'(bcd_h), 32'h01);
      if (c == 8) chk("pulse4_after", 32'(bcd_h), 32'h02);
    end
    chk("pulse4_once", 32'(bcd_h), 32'h02);
    apply(5, 5);
    btn_mode = 1'b1;
    btn_inc = 1'b1;
    repeat (10) step;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    repeat (10) step;
    chk("collide_edit", 32'(edit), 32'h1);
    chk("collide_h", 32'(bcd_h), 32'h23);
    apply(6, 6);
    pulse(1'b1);
    chk("preload_edit", 32'(edit), 32'h0);
    chk("preload_hms", {8'h0, bcd_h, bcd_m, bcd_s}, 32'h235901);
    repeat (57) wait_tick(n);
    chk("roll_235958", {8'h0, bcd_h, bcd_m, bcd_s}, 32'h235958);
    wait_tick(n);
    chk("roll_235959", {8'h0, bcd_h, bcd_m, bcd_s}, 32'h235959);
    wait_tick(n);
    chk("roll_000000", {8'h0, bcd_h, bcd_m, bcd_s}, 32'h000000);
    repeat (59) wait_tick(n);
    chk("roll_000059", {8'h0, bcd_h, bcd_m, bcd_s}, 32'h000059);
    wait_tick(n);
    chk("roll_000100", {8'h0, bcd_h, bcd_m, bcd_s}, 32'h000100);
    pulse(1'b1);
    pulse(1'b1);
    chk("pre_reset_edit", 32'(edit), 32'h1);
    reset = 1'b1;
    step;
    reset = 1'b0;
    chk("mid_reset_hms", {8'h0, bcd_h, bcd_m, bcd_s}, 32'h000000);
    chk("mid_reset_edit", 32'(edit), 32'h0);
    chk("mid_reset_tick", 32'(tick_1hz), 32'h0);
    wait_tick(n);
    chk("mid_reset_first_tick", 32'(n), 32'd10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
